// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch (IF) and data (D) paths
//   i_clk, i_rst_n                          clock, async active-low reset
//   i_if_req/i_if_addr -> o_if_gnt          fetch request, comb grant
//   o_if_rvalid/o_if_rdata, o_stall_if      fetch response pulse, registered data, fetch stall
//   i_d_req/i_d_we/i_d_addr/i_d_wdata       data request (load/store)
//   o_d_gnt, o_d_rvalid/o_d_rdata           data grant, response pulse, registered load data
//   o_mem_en/we/addr/wdata, i_mem_rdata/i_mem_ready   registered memory access, memory response
//   o_bus_err                               pulses with rvalid when the watchdog aborts an access
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_stall_if,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ready,
  output logic              o_bus_err
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);
  localparam logic [7:0] WDOG_LAST  = 8'(TIMEOUT - 1);
  state_t            r_state;
  logic [3:0]        r_streak;
  logic [7:0]        r_wdog;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_if_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_d_rvalid;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_bus_err;
  logic              w_idle;
  logic              w_d_gnt;
  logic              w_if_gnt;
  logic              w_done;
  // grants are suppressed while reset is asserted even though the state already reads IDLE
  assign w_idle   = i_rst_n && r_state == IDLE;
  // D wins a collision unless fetch has already lost MAX_STREAK times in a row
  assign w_d_gnt  = w_idle && i_d_req && !(i_if_req && r_streak == STREAK_MAX);
  assign w_if_gnt = w_idle && i_if_req && !w_d_gnt;
  // an access ends on ready or when the watchdog's last allowed BUSY cycle passes without it
  assign w_done   = i_mem_ready || r_wdog == WDOG_LAST;
  assign o_if_gnt    = w_if_gnt;
  assign o_d_gnt     = w_d_gnt;
  assign o_stall_if  = i_rst_n && i_if_req && !w_if_gnt;
  assign o_if_rvalid = r_if_rvalid;
  assign o_if_rdata  = r_if_rdata;
  assign o_d_rvalid  = r_d_rvalid;
  assign o_d_rdata   = r_d_rdata;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_bus_err   = r_bus_err;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_streak    <= '0;
      r_wdog      <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rvalid  <= 1'b0;
      r_d_rdata   <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_bus_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_d_gnt) begin
            r_state     <= BUSY_D;
            r_mem_en    <= 1'b1;
            r_mem_we    <= i_d_we;
            r_mem_addr  <= i_d_addr;
            r_mem_wdata <= i_d_wdata;
            r_wdog      <= '0;
            r_streak    <= !i_if_req ? 4'd0 : r_streak == STREAK_MAX ? r_streak : r_streak + 4'd1;
          end else if (w_if_gnt) begin
            r_state    <= BUSY_IF;
            r_mem_en   <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= i_if_addr;
            r_wdog     <= '0;
            r_streak   <= '0;
          end
        end
        default: begin
          if (w_done) begin
            r_state   <= IDLE;
            r_mem_en  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_bus_err <= !i_mem_ready;
            if (r_state == BUSY_IF) begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= i_mem_ready ? i_mem_rdata : '0;
            end else begin
              r_d_rvalid <= 1'b1;
              // a completed store leaves the last load data in place; an abort always zeroes it
              if (!i_mem_ready || !r_mem_we) r_d_rdata <= i_mem_ready ? i_mem_rdata : '0;
            end
          end else begin
            r_wdog <= r_wdog + 8'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, corner-case sequences and randomized model check of mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int MAXS = 4;
  localparam int TOUT = 16;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_gnt, if_rvalid, stall_if;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we, mem_ready, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(MAXS), .TIMEOUT(TOUT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid),
    .o_if_rdata(if_rdata), .o_stall_if(stall_if),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready), .o_bus_err(bus_err)
  );
  typedef struct {
    logic        ifr;
    logic        dr;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        eig;
    logic        edg;
    logic [31:0] erd;
  } vec_t;
  vec_t tbl[6];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  task automatic idle_inputs();
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
  endtask
  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask
  task automatic d_load(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk); d_req = 1; d_we = 0; d_addr = a;
    @(negedge clk); d_req = 0; mem_ready = 1; mem_rdata = v;
    @(negedge clk); mem_ready = 0;
  endtask
  // reference model state for the randomized phase
  int          owner, streak, waitc;
  logic        m_we, if_pend, d_pend, eg_d, eg_if, exp_ifv, exp_dv;
  logic [31:0] m_addr, m_wdata, exp_ifd, exp_dd;
  int          gseq[$];
  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h100,      32'h0,        32'h00500093, 1'b1, 1'b0, 32'h00500093};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h40,       32'h0,        32'h11223344, 1'b0, 1'b1, 32'h11223344};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h200,      32'hDEADBEEF, 32'h55555555, 1'b0, 1'b1, 32'h11223344};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 32'h300,      32'h0,        32'h77777777, 1'b0, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0,        32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 32'h0};
    rst_n = 0;
    idle_inputs();
    if_req = 1; d_req = 1;
    #1;
    chk("rst_if_gnt", {31'b0, if_gnt}, 0);
    chk("rst_d_gnt", {31'b0, d_gnt}, 0);
    chk("rst_stall", {31'b0, stall_if}, 0);
    chk("rst_mem_en", {31'b0, mem_en}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_d_rdata", d_rdata, 0);
    do_reset();
    // single transactions from IDLE with a zero-wait memory
    foreach (tbl[k]) begin
      @(negedge clk);
      if_req = tbl[k].ifr; d_req = tbl[k].dr; d_we = tbl[k].we;
      if_addr = tbl[k].addr; d_addr = tbl[k].addr; d_wdata = tbl[k].wdata;
      #1;
      chk($sformatf("v%0d_if_gnt", k), {31'b0, if_gnt}, {31'b0, tbl[k].eig});
      chk($sformatf("v%0d_d_gnt", k), {31'b0, d_gnt}, {31'b0, tbl[k].edg});
      chk($sformatf("v%0d_stall", k), {31'b0, stall_if}, 0);
      @(negedge clk);
      if_req = 0; d_req = 0; mem_ready = 1; mem_rdata = tbl[k].rdata;
      #1;
      chk($sformatf("v%0d_mem_en", k), {31'b0, mem_en}, {31'b0, tbl[k].eig | tbl[k].edg});
      if (tbl[k].eig | tbl[k].edg) begin
        chk($sformatf("v%0d_mem_addr", k), mem_addr, tbl[k].addr);
        chk($sformatf("v%0d_mem_we", k), {31'b0, mem_we}, {31'b0, tbl[k].edg & tbl[k].we});
      end
      if (tbl[k].edg & tbl[k].we) chk($sformatf("v%0d_mem_wdata", k), mem_wdata, tbl[k].wdata);
      @(negedge clk);
      mem_ready = 0;
      #1;
      chk($sformatf("v%0d_if_rvalid", k), {31'b0, if_rvalid}, {31'b0, tbl[k].eig});
      chk($sformatf("v%0d_d_rvalid", k), {31'b0, d_rvalid}, {31'b0, tbl[k].edg});
      chk($sformatf("v%0d_bus_err", k), {31'b0, bus_err}, 0);
      if (tbl[k].eig) chk($sformatf("v%0d_if_rdata", k), if_rdata, tbl[k].erd);
      if (tbl[k].edg) chk($sformatf("v%0d_d_rdata", k), d_rdata, tbl[k].erd);
    end
    // reset in the middle of a data access
    @(negedge clk); d_req = 1; d_we = 0; d_addr = 32'h300;
    @(negedge clk); d_req = 0; if_req = 1; if_addr = 32'h140;
    #1;
    chk("mid_busy_mem_en", {31'b0, mem_en}, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_mem_en", {31'b0, mem_en}, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_if_gnt", {31'b0, if_gnt}, 0);
    chk("mid_rst_stall", {31'b0, stall_if}, 0);
    @(negedge clk); rst_n = 1;
    #1;
    chk("post_rst_if_gnt", {31'b0, if_gnt}, 1);
    @(negedge clk); if_req = 0; mem_ready = 1; mem_rdata = 32'h00A00113;
    #1;
    chk("post_rst_mem_addr", mem_addr, 32'h140);
    chk("post_rst_no_d_rvalid", {31'b0, d_rvalid}, 0);
    @(negedge clk); mem_ready = 0;
    #1;
    chk("post_rst_if_rvalid", {31'b0, if_rvalid}, 1);
    chk("post_rst_if_rdata", if_rdata, 32'h00A00113);
    chk("post_rst_d_rvalid", {31'b0, d_rvalid}, 0);
    // collision: store wins, fetch stalls until the next IDLE cycle
    do_reset();
    d_load(32'h44, 32'h0BADF00D);
    @(negedge clk);
    if_req = 1; if_addr = 32'h100; d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
    #1;
    chk("col_d_gnt", {31'b0, d_gnt}, 1);
    chk("col_if_gnt", {31'b0, if_gnt}, 0);
    chk("col_stall0", {31'b0, stall_if}, 1);
    @(negedge clk); d_req = 0; mem_ready = 1; mem_rdata = 32'h55;
    #1;
    chk("col_mem_we", {31'b0, mem_we}, 1);
    chk("col_mem_addr", mem_addr, 32'h200);
    chk("col_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("col_stall1", {31'b0, stall_if}, 1);
    @(negedge clk); mem_ready = 0;
    #1;
    chk("col_d_rvalid", {31'b0, d_rvalid}, 1);
    chk("col_d_rdata_kept", d_rdata, 32'h0BADF00D);
    chk("col_if_gnt2", {31'b0, if_gnt}, 1);
    chk("col_stall2", {31'b0, stall_if}, 0);
    @(negedge clk); if_req = 0; mem_ready = 1; mem_rdata = 32'h13;
    #1;
    chk("col_if_mem_we", {31'b0, mem_we}, 0);
    chk("col_if_mem_addr", mem_addr, 32'h100);
    @(negedge clk); mem_ready = 0;
    #1;
    chk("col_if_rvalid", {31'b0, if_rvalid}, 1);
    chk("col_if_rdata", if_rdata, 32'h13);
    // starvation guard: D, D, D, D, IF, D with both requests held
    do_reset();
    gseq.delete();
    for (int c = 0; c < 20 && gseq.size() < 6; c++) begin
      @(negedge clk);
      if_req = 1; d_req = 1; d_we = 0; mem_ready = 1;
      #1;
      if (if_gnt && d_gnt) gseq.push_back(3);
      else if (d_gnt) gseq.push_back(2);
      else if (if_gnt) gseq.push_back(1);
    end
    chk("starve_grant_count", gseq.size(), 6);
    foreach (gseq[k]) chk($sformatf("starve_grant%0d", k), gseq[k], k == 4 ? 1 : 2);
    @(negedge clk); if_req = 0; d_req = 0;
    @(negedge clk); mem_ready = 0;
    // three wait states on a load, fetch held off meanwhile
    do_reset();
    @(negedge clk); d_req = 1; d_we = 0; d_addr = 32'h40;
    #1;
    chk("ws_d_gnt", {31'b0, d_gnt}, 1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      d_req = 0; if_req = 1; if_addr = 32'h500;
      mem_ready = (c == 4); mem_rdata = (c == 4) ? 32'hCAFEF00D : 32'h0;
      #1;
      chk($sformatf("ws_mem_en%0d", c), {31'b0, mem_en}, 1);
      chk($sformatf("ws_if_gnt%0d", c), {31'b0, if_gnt}, 0);
      chk($sformatf("ws_d_rvalid%0d", c), {31'b0, d_rvalid}, 0);
    end
    @(negedge clk); mem_ready = 0;
    #1;
    chk("ws_d_rvalid", {31'b0, d_rvalid}, 1);
    chk("ws_d_rdata", d_rdata, 32'hCAFEF00D);
    chk("ws_mem_en_off", {31'b0, mem_en}, 0);
    chk("ws_if_gnt", {31'b0, if_gnt}, 1);
    @(negedge clk); if_req = 0; mem_ready = 1;
    @(negedge clk); mem_ready = 0;
    // hung access: watchdog abort after TOUT BUSY cycles, then the pending fetch is served
    do_reset();
    d_load(32'h10, 32'h12345678);
    @(negedge clk); d_req = 1; d_we = 0; d_addr = 32'h80; if_req = 1; if_addr = 32'h600;
    #1;
    chk("hang_d_gnt", {31'b0, d_gnt}, 1);
    for (int c = 1; c <= TOUT; c++) begin
      @(negedge clk); d_req = 0;
      #1;
      chk($sformatf("hang_mem_en%0d", c), {31'b0, mem_en}, 1);
      chk($sformatf("hang_d_rvalid%0d", c), {31'b0, d_rvalid}, 0);
      chk($sformatf("hang_if_gnt%0d", c), {31'b0, if_gnt}, 0);
    end
    @(negedge clk);
    #1;
    chk("hang_d_rvalid", {31'b0, d_rvalid}, 1);
    chk("hang_bus_err", {31'b0, bus_err}, 1);
    chk("hang_d_rdata", d_rdata, 0);
    chk("hang_mem_en_off", {31'b0, mem_en}, 0);
    chk("hang_if_gnt", {31'b0, if_gnt}, 1);
    @(negedge clk); if_req = 0; mem_ready = 1; mem_rdata = 32'h600DF00D;
    #1;
    chk("hang_bus_err_pulse", {31'b0, bus_err}, 0);
    chk("hang_if_mem_addr", mem_addr, 32'h600);
    @(negedge clk); mem_ready = 0;
    #1;
    chk("hang_if_rvalid", {31'b0, if_rvalid}, 1);
    chk("hang_if_rdata", if_rdata, 32'h600DF00D);
    // randomized traffic against the reference model
    do_reset();
    owner = 0; streak = 0; waitc = 0; if_pend = 0; d_pend = 0;
    exp_ifv = 0; exp_dv = 0; exp_ifd = 0; exp_dd = 0; m_we = 0; m_addr = 0; m_wdata = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1; if_addr = $urandom & 32'hFFFFFFFC;
      end
      if (!d_pend && $urandom_range(0, 1) == 0) begin
        d_pend = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
      end
      if_req = if_pend; d_req = d_pend;
      mem_ready = (owner != 0 && waitc >= 5) ? 1'b1 : 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      #1;
      eg_d  = owner == 0 && d_pend && !(if_pend && streak == MAXS);
      eg_if = owner == 0 && if_pend && !eg_d;
      chk("rnd_d_gnt", {31'b0, d_gnt}, {31'b0, eg_d});
      chk("rnd_if_gnt", {31'b0, if_gnt}, {31'b0, eg_if});
      chk("rnd_stall", {31'b0, stall_if}, {31'b0, if_pend & ~eg_if});
      chk("rnd_mem_en", {31'b0, mem_en}, {31'b0, owner != 0});
      if (owner != 0) begin
        chk("rnd_mem_addr", mem_addr, m_addr);
        chk("rnd_mem_we", {31'b0, mem_we}, {31'b0, m_we});
        if (m_we) chk("rnd_mem_wdata", mem_wdata, m_wdata);
      end
      chk("rnd_if_rvalid", {31'b0, if_rvalid}, {31'b0, exp_ifv});
      chk("rnd_d_rvalid", {31'b0, d_rvalid}, {31'b0, exp_dv});
      chk("rnd_bus_err", {31'b0, bus_err}, 0);
      if (exp_ifv) chk("rnd_if_rdata", if_rdata, exp_ifd);
      if (exp_dv) chk("rnd_d_rdata", d_rdata, exp_dd);
      exp_ifv = 0; exp_dv = 0;
      if (owner == 0) begin
        if (eg_d) begin
          owner = 2; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; waitc = 0; d_pend = 0;
          streak = if_pend ? (streak < MAXS ? streak + 1 : streak) : 0;
        end else if (eg_if) begin
          owner = 1; m_we = 0; m_addr = if_addr; waitc = 0; if_pend = 0; streak = 0;
        end
      end else if (mem_ready) begin
        if (owner == 1) begin
          exp_ifv = 1; exp_ifd = mem_rdata;
        end else begin
          exp_dv = 1;
          if (!m_we) exp_dd = mem_rdata;
        end
        owner = 0;
      end else begin
        waitc++;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
